f9pcap_frame_parser: RTL and testbench
======================================

# f9pcap_frame_parser

Byte-stream consumer for the TEMAC-side output of `f9pcap_sfp_to_temac`. Each f9pcap frame carries an Ethernet/IPv4/UDP header (42 bytes) plus a 16-byte f9pcap header, followed by the captured SFP payload. The block validates the 58 header bytes against the f9pcap configuration and extracts the f9pcap fields. It forwards the payload on an AXI-stream and maintains status counters; it is used in loopback checkers and the capture-replay path.

## Interface
- `DATA_WIDTH`, 8, stream width (one byte per beat).
- `TTS_WIDTH`, 64, timestamp width in the f9pcap header.
- `SFP_COUNT`, 2, number of source SFP ports tracked for sequence checking.
- `FRAME_MAX_LENGTH`, 1600, maximum accepted frame length in bytes.
- `CNT_WIDTH`, 32, width of each status counter.

Ports:
- `clk_in`  in  1  single clock.
- `rst_n_in`  in  1  asynchronous, active-low reset.
- `f9pcap_mcgroup_addr`  in  32  expected IP destination.
- `f9pcap_mcgroup_port`  in  16  expected UDP destination port.
- `f9pcap_src_mac_addr`  in  48  expected Ethernet source MAC.
- `f9pcap_src_ip_addr`  in  32  expected IP source.
- `f9pcap_src_port`  in  16  expected UDP source port.
- `s_valid_in` / `s_ready_out` / `s_data_in[DATA_WIDTH]` / `s_last_in`  in/out/in/in  input frame stream.
- `m_valid_out` / `m_ready_in` / `m_data_out[DATA_WIDTH]` / `m_last_out` / `m_err_out`  out/in/out/out/out  payload stream.
- `hdr_valid_out`  out  1  one-cycle pulse; the header fields below are valid on this cycle.
- `hdr_tts_out`  out  TTS_WIDTH  f9pcap timestamp.
- `hdr_port_out`  out  16  source SFP port index.
- `hdr_len_out`  out  16  payload length.
- `hdr_seq_out`  out  32  f9pcap sequence number.
- `cnt_ok_out`  out  CNT_WIDTH  frame-OK counter.
- `cnt_hdr_err_out`  out  CNT_WIDTH  header-error counter.
- `cnt_len_err_out`  out  CNT_WIDTH  length-error counter.
- `cnt_seq_gap_out`  out  CNT_WIDTH  sequence-gap counter.

## Operation
- **Header layout** (byte offsets, big-endian):
  - Destination MAC at 0–5 = 01:00:5e followed by the low 23 bits of `f9pcap_mcgroup_addr`.
  - Source MAC at 6–11 = `f9pcap_src_mac_addr`; ethertype at 12–13 = 0x0800.
  - IP byte at 14 = 0x45; IP protocol at 23 = 0x11.
  - Source IP at 26–29 = `f9pcap_src_ip_addr`; destination IP at 30–33 = `f9pcap_mcgroup_addr`.
  - UDP source port at 34–35 = `f9pcap_src_port`; UDP destination port at 36–37 = `f9pcap_mcgroup_port`.
  - Remaining IP and UDP fields, including checksums, are ignored.
  - f9pcap header: tts at 42–49, port at 50–51, length at 52–53, sequence at 54–57.
- **States**:
  - `HDR`: byte counter 0..57; each byte is compared and a sticky mismatch flag is kept.
    - At byte 57 with no mismatch and port < SFP_COUNT → `PAY`.
    - At byte 57 with a mismatch or port ≥ SFP_COUNT → `DROP`, and `cnt_hdr_err` increments.
    - `s_last` before byte 57 (runt frame) → stay in `HDR`, `cnt_hdr_err` increments, counter resets.
  - `PAY`: payload bytes are forwarded.
    - On `s_last` → `HDR`.
    - If the total byte count reaches FRAME_MAX_LENGTH without `s_last` → `DROP`, and `cnt_len_err` increments once.
  - `DROP`: bytes are consumed and discarded until `s_last` → `HDR`.
- **Length check**: on the final payload byte, a payload byte count ≠ `hdr_len` sets `m_err_out` together with `m_last_out` and increments `cnt_len_err`; otherwise `cnt_ok` increments. A frame whose header is valid but carries zero payload bytes counts as a length error (no beat is emitted).
- **Sequence check**: the block holds an expected sequence number and a `seen` flag per port. If `seen` is set and seq ≠ expected, `cnt_seq_gap` increments. After the check, expected = seq + 1 (wrapping at 2^32) and `seen` is set.
- **Counters**: saturate at all-ones; no wrap.

## Timing
- Reset (asynchronous): state `HDR`, byte counter 0, every output 0, `seen` flags cleared. Exception: `s_ready_out` is 0 during reset and 1 from the first clock after deassert.
- `s_ready_out`:
  - 1 in `HDR` and `DROP`.
  - `m_ready_in` in `PAY`, combinational.
- Payload path is zero-latency pass-through:
  - `m_valid_out` = `s_valid_in` && state == `PAY`.
  - `m_data_out` and `m_last_out` are driven directly from the input.
- `hdr_valid_out` pulses on the cycle after byte 57 is accepted with a valid header. This is before or coincident with the first payload beat. Header outputs hold their value until the next pulse.
- Counters and the sequence check update on the cycle after the deciding beat is accepted.
- `s_last` on byte 57 of a valid header: the frame has no payload. It counts as a length error and the block stays in `HDR`.

## Structure
- Shared package holds:
  - header offset constants: `F9HDR_ETH_LEN`=14, `F9HDR_IPUDP_LEN`=28, `F9PCAP_A_HDR_LENGTH`=58;
  - the ethertype and protocol constants;
  - the state enum.
- Sub-module `f9pcap_sat_counter` (parameter `CNT_WIDTH`; ports `inc`, `cnt`) is instantiated four times.

## Test plan
- Configuration for all cases: mcgroup 01020304:0506, source f1f2f3f4f5f6 / 0708090a:0b0c.
- Valid frame, port 0, len 64, seq 5, payload 00..3f → 64 beats 00..3f, `m_last` on 3f, `m_err`=0, `hdr_tts` matches, `cnt_ok`=1.
- Same frame with UDP destination port 0507 → no `m_valid`, `cnt_hdr_err`=1; the next valid frame passes.
- Header length field 64 but 60 payload bytes sent → `m_err`=1 on beat 60, `cnt_len_err`=1.
- Port 1 frames with seq 7, 8, 10 → `cnt_seq_gap`=1.
- 30-byte runt frame, then a valid frame → `cnt_hdr_err`=1; the second frame is forwarded intact.
- `m_ready` toggled every other cycle during payload → no byte lost or duplicated.
- `rst_n_in` pulsed mid-payload → all outputs 0 immediately; the next frame parses correctly.

Source files
------------

// File: rtl/f9pcap_frame_parser_pkg.sv
// Shared definitions for the f9pcap frame parser.
// Holds the header geometry, the fixed protocol constants checked in the
// Ethernet/IPv4 header, and the parser state encoding.
package f9pcap_frame_parser_pkg;

  localparam int F9HDR_ETH_LEN       = 14;
  localparam int F9HDR_IPUDP_LEN     = 28;
  localparam int F9PCAP_A_HDR_LENGTH = 58;
  // First byte of the f9pcap header (tts) follows Ethernet + IP + UDP.
  localparam int F9PCAP_OFS          = F9HDR_ETH_LEN + F9HDR_IPUDP_LEN;

  localparam logic [15:0] F9_ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  F9_IP_VER_IHL     = 8'h45;
  localparam logic [7:0]  F9_IP_PROTO_UDP   = 8'h11;
  localparam logic [23:0] F9_MCAST_OUI      = 24'h01005e;

  typedef enum logic [1:0] {
    ST_HDR  = 2'd0,
    ST_PAY  = 2'd1,
    ST_DROP = 2'd2
  } f9_state_e;

endpackage

// File: rtl/f9pcap_frame_parser_if.sv
// Byte stream bundle used for both the input frame stream and the payload
// stream of the f9pcap frame parser.
//   valid/ready : a beat transfers on a clock edge where valid && ready are
//                 both 1. The master keeps valid, data, last and err stable
//                 until the beat transfers; ready may change freely and may
//                 depend combinationally on valid.
//   data        : one byte per beat.
//   last        : marks the final beat of a frame.
//   err         : qualifies the last beat; 1 when the frame length was wrong.
interface f9pcap_frame_parser_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;
  logic                  last;
  logic                  err;

  modport master (output valid, data, last, err, input ready);
  modport slave  (input valid, data, last, output ready);
endinterface

// File: rtl/f9pcap_sat_counter.sv
// Saturating event counter: counts inc pulses, holds at all-ones.
// Ports: clk_in, rst_n_in (async active-low), inc (count enable), cnt (value).
module f9pcap_sat_counter #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] cnt
);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cnt <= '0;
    end else if (inc && (cnt != {CNT_WIDTH{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/f9pcap_frame_parser.sv
// f9pcap frame parser: checks the 58-byte Ethernet/IPv4/UDP + f9pcap header
// against the configured addresses, extracts the f9pcap fields, forwards the
// payload with zero latency and keeps saturating status counters.
// Ports:
//   clk_in, rst_n_in            clock, asynchronous active-low reset
//   f9pcap_*                    expected header addresses and ports
//   s_if (slave)                input frame stream
//   m_if (master)               payload stream (err on last = bad length)
//   hdr_*_out                   extracted fields, valid with hdr_valid_out
//   cnt_*_out                   ok / header-error / length-error / seq-gap
//   dbg_state_out               current parser state
module f9pcap_frame_parser
  import f9pcap_frame_parser_pkg::*;
#(
  parameter int DATA_WIDTH       = 8,
  parameter int TTS_WIDTH        = 64,
  parameter int SFP_COUNT        = 2,
  parameter int FRAME_MAX_LENGTH = 1600,
  parameter int CNT_WIDTH        = 32
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic [31:0]           f9pcap_mcgroup_addr,
  input  logic [15:0]           f9pcap_mcgroup_port,
  input  logic [47:0]           f9pcap_src_mac_addr,
  input  logic [31:0]           f9pcap_src_ip_addr,
  input  logic [15:0]           f9pcap_src_port,
  f9pcap_frame_parser_if.slave  s_if,
  f9pcap_frame_parser_if.master m_if,
  output logic                  hdr_valid_out,
  output logic [TTS_WIDTH-1:0]  hdr_tts_out,
  output logic [15:0]           hdr_port_out,
  output logic [15:0]           hdr_len_out,
  output logic [31:0]           hdr_seq_out,
  output logic [CNT_WIDTH-1:0]  cnt_ok_out,
  output logic [CNT_WIDTH-1:0]  cnt_hdr_err_out,
  output logic [CNT_WIDTH-1:0]  cnt_len_err_out,
  output logic [CNT_WIDTH-1:0]  cnt_seq_gap_out,
  output f9_state_e             dbg_state_out
);

  localparam int          PW      = (SFP_COUNT > 1) ? $clog2(SFP_COUNT) : 1;
  localparam logic [15:0] MAX_W   = 16'(FRAME_MAX_LENGTH);
  localparam logic [15:0] NPORT_W = 16'(SFP_COUNT);
  localparam logic [15:0] HEND_W  = 16'(F9PCAP_A_HDR_LENGTH - 1);
  localparam logic [15:0] OFS_W   = 16'(F9PCAP_OFS);

  f9_state_e              r_state, w_state_nxt;
  logic                   r_rdy_en;
  logic [15:0]            r_byte_cnt;
  logic                   r_mis;
  logic [TTS_WIDTH-1:0]   r_tts_sh;
  logic [15:0]            r_port_sh, r_len_sh;
  logic [31:0]            r_seq_sh;
  logic [31:0]            r_exp_seq [SFP_COUNT];
  logic [SFP_COUNT-1:0]   r_seen;
  logic                   r_hdr_valid;
  logic [TTS_WIDTH-1:0]   r_hdr_tts;
  logic [15:0]            r_hdr_port, r_hdr_len;
  logic [31:0]            r_hdr_seq;

  logic [DATA_WIDTH-1:0]  w_byte;
  logic [7:0]             w_exp;
  logic                   w_chk, w_acc, w_pay, w_mis_all, w_hdr_end, w_hdr_good;
  logic [31:0]            w_seq;
  logic [PW-1:0]          w_pidx;
  logic [15:0]            w_pay_cnt;
  logic                   w_len_bad, w_hdr_fire;
  logic                   w_inc_ok, w_inc_hdr, w_inc_len, w_inc_gap;

  assign w_byte = s_if.data;
  assign w_pay  = (r_state == ST_PAY);
  assign w_acc  = s_if.valid && s_if.ready;

  // Stream glue: ready is held low until the first clock after reset.
  assign s_if.ready = r_rdy_en && (!w_pay || m_if.ready);
  assign m_if.valid = s_if.valid && w_pay;
  assign m_if.data  = w_pay ? s_if.data : {DATA_WIDTH{1'b0}};
  assign m_if.last  = w_pay && s_if.last;
  assign m_if.err   = w_pay && s_if.last && w_len_bad;

  // Expected value of each checked header byte; unchecked bytes clear w_chk.
  always_comb begin
    w_chk = 1'b1;
    w_exp = 8'h00;
    case (r_byte_cnt)
      16'd0:  w_exp = F9_MCAST_OUI[23:16];
      16'd1:  w_exp = F9_MCAST_OUI[15:8];
      16'd2:  w_exp = F9_MCAST_OUI[7:0];
      16'd3:  w_exp = {1'b0, f9pcap_mcgroup_addr[22:16]};
      16'd4:  w_exp = f9pcap_mcgroup_addr[15:8];
      16'd5:  w_exp = f9pcap_mcgroup_addr[7:0];
      16'd6:  w_exp = f9pcap_src_mac_addr[47:40];
      16'd7:  w_exp = f9pcap_src_mac_addr[39:32];
      16'd8:  w_exp = f9pcap_src_mac_addr[31:24];
      16'd9:  w_exp = f9pcap_src_mac_addr[23:16];
      16'd10: w_exp = f9pcap_src_mac_addr[15:8];
      16'd11: w_exp = f9pcap_src_mac_addr[7:0];
      16'd12: w_exp = F9_ETHERTYPE_IPV4[15:8];
      16'd13: w_exp = F9_ETHERTYPE_IPV4[7:0];
      16'(F9HDR_ETH_LEN):     w_exp = F9_IP_VER_IHL;
      16'(F9HDR_ETH_LEN + 9): w_exp = F9_IP_PROTO_UDP;
      16'd26: w_exp = f9pcap_src_ip_addr[31:24];
      16'd27: w_exp = f9pcap_src_ip_addr[23:16];
      16'd28: w_exp = f9pcap_src_ip_addr[15:8];
      16'd29: w_exp = f9pcap_src_ip_addr[7:0];
      16'd30: w_exp = f9pcap_mcgroup_addr[31:24];
      16'd31: w_exp = f9pcap_mcgroup_addr[23:16];
      16'd32: w_exp = f9pcap_mcgroup_addr[15:8];
      16'd33: w_exp = f9pcap_mcgroup_addr[7:0];
      16'd34: w_exp = f9pcap_src_port[15:8];
      16'd35: w_exp = f9pcap_src_port[7:0];
      16'd36: w_exp = f9pcap_mcgroup_port[15:8];
      16'd37: w_exp = f9pcap_mcgroup_port[7:0];
      default: w_chk = 1'b0;
    endcase
  end

  assign w_mis_all  = r_mis || (w_chk && (w_byte != w_exp));
  assign w_hdr_end  = (r_byte_cnt == HEND_W);
  assign w_hdr_good = !w_mis_all && (r_port_sh < NPORT_W);
  assign w_seq      = {r_seq_sh[23:0], w_byte};
  assign w_pidx     = r_port_sh[PW-1:0];
  // Payload bytes including the current beat (first payload beat -> 1).
  assign w_pay_cnt  = r_byte_cnt - HEND_W;
  assign w_len_bad  = (w_pay_cnt != r_len_sh);
  assign w_inc_gap  = w_hdr_fire && r_seen[w_pidx] && (w_seq != r_exp_seq[w_pidx]);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) r_state <= ST_HDR;
    else           r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_hdr_fire  = 1'b0;
    w_inc_ok    = 1'b0;
    w_inc_hdr   = 1'b0;
    w_inc_len   = 1'b0;
    case (r_state)
      ST_HDR: begin
        if (w_acc) begin
          if (w_hdr_end) begin
            if (w_hdr_good) begin
              w_hdr_fire = 1'b1;
              // last on the final header byte: empty payload is a length error.
              if (s_if.last) w_inc_len   = 1'b1;
              else           w_state_nxt = ST_PAY;
            end else begin
              w_inc_hdr = 1'b1;
              if (!s_if.last) w_state_nxt = ST_DROP;
            end
          end else if (s_if.last) begin
            w_inc_hdr = 1'b1;  // runt frame
          end
        end
      end
      ST_PAY: begin
        if (w_acc) begin
          if (s_if.last) begin
            w_state_nxt = ST_HDR;
            if (w_len_bad) w_inc_len = 1'b1;
            else           w_inc_ok  = 1'b1;
          end else if ((r_byte_cnt + 16'd1) == MAX_W) begin
            w_state_nxt = ST_DROP;
            w_inc_len   = 1'b1;
          end
        end
      end
      ST_DROP: begin
        if (w_acc && s_if.last) w_state_nxt = ST_HDR;
      end
      default: w_state_nxt = ST_HDR;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_rdy_en    <= 1'b0;
      r_byte_cnt  <= '0;
      r_mis       <= 1'b0;
      r_tts_sh    <= '0;
      r_port_sh   <= '0;
      r_len_sh    <= '0;
      r_seq_sh    <= '0;
      r_seen      <= '0;
      for (int i = 0; i < SFP_COUNT; i++) r_exp_seq[i] <= '0;
      r_hdr_valid <= 1'b0;
      r_hdr_tts   <= '0;
      r_hdr_port  <= '0;
      r_hdr_len   <= '0;
      r_hdr_seq   <= '0;
    end else begin
      r_rdy_en    <= 1'b1;
      r_hdr_valid <= w_hdr_fire;
      if (w_acc) begin
        r_byte_cnt <= s_if.last ? 16'd0 : r_byte_cnt + 16'd1;
        r_mis      <= s_if.last ? 1'b0 : w_mis_all;
        if (r_state == ST_HDR) begin
          if (r_byte_cnt >= OFS_W && r_byte_cnt < OFS_W + 16'd8)
            r_tts_sh <= {r_tts_sh[TTS_WIDTH-9:0], w_byte};
          if (r_byte_cnt >= OFS_W + 16'd8 && r_byte_cnt < OFS_W + 16'd10)
            r_port_sh <= {r_port_sh[7:0], w_byte};
          if (r_byte_cnt >= OFS_W + 16'd10 && r_byte_cnt < OFS_W + 16'd12)
            r_len_sh <= {r_len_sh[7:0], w_byte};
          if (r_byte_cnt >= OFS_W + 16'd12)
            r_seq_sh <= w_seq;
        end
      end
      if (w_hdr_fire) begin
        r_hdr_tts         <= r_tts_sh;
        r_hdr_port        <= r_port_sh;
        r_hdr_len         <= r_len_sh;
        r_hdr_seq         <= w_seq;
        r_exp_seq[w_pidx] <= w_seq + 32'd1;
        r_seen[w_pidx]    <= 1'b1;
      end
    end
  end

  assign hdr_valid_out = r_hdr_valid;
  assign hdr_tts_out   = r_hdr_tts;
  assign hdr_port_out  = r_hdr_port;
  assign hdr_len_out   = r_hdr_len;
  assign hdr_seq_out   = r_hdr_seq;
  assign dbg_state_out = r_state;

  f9pcap_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt_ok (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .inc(w_inc_ok), .cnt(cnt_ok_out));
  f9pcap_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt_hdr (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .inc(w_inc_hdr), .cnt(cnt_hdr_err_out));
  f9pcap_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt_len (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .inc(w_inc_len), .cnt(cnt_len_err_out));
  f9pcap_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt_gap (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .inc(w_inc_gap), .cnt(cnt_seq_gap_out));

endmodule

// File: tb/tb_f9pcap_frame_parser.sv
`timescale 1ns/1ps
module tb_f9pcap_frame_parser;
  import f9pcap_frame_parser_pkg::*;

  localparam int W = 10;  // {last, err, data}

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mc_addr  = 32'h01020304;
  logic [15:0] mc_port  = 16'h0506;
  logic [47:0] src_mac  = 48'hf1f2f3f4f5f6;
  logic [31:0] src_ip   = 32'h0708090a;
  logic [15:0] src_port = 16'h0b0c;

  f9pcap_frame_parser_if #(.DATA_WIDTH(8)) s_if ();
  f9pcap_frame_parser_if #(.DATA_WIDTH(8)) m_if ();

  logic        hdr_valid;
  logic [63:0] hdr_tts;
  logic [15:0] hdr_port, hdr_len;
  logic [31:0] hdr_seq;
  logic [31:0] cnt_ok, cnt_hdr, cnt_len, cnt_gap;
  f9_state_e   dbg_state;

  f9pcap_frame_parser dut (
    .clk_in(clk), .rst_n_in(rst_n),
    .f9pcap_mcgroup_addr(mc_addr), .f9pcap_mcgroup_port(mc_port),
    .f9pcap_src_mac_addr(src_mac), .f9pcap_src_ip_addr(src_ip),
    .f9pcap_src_port(src_port),
    .s_if(s_if), .m_if(m_if),
    .hdr_valid_out(hdr_valid), .hdr_tts_out(hdr_tts), .hdr_port_out(hdr_port),
    .hdr_len_out(hdr_len), .hdr_seq_out(hdr_seq),
    .cnt_ok_out(cnt_ok), .cnt_hdr_err_out(cnt_hdr), .cnt_len_err_out(cnt_len),
    .cnt_seq_gap_out(cnt_gap), .dbg_state_out(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int           n_tests = 0;
  int           n_fail  = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_b, act_b;
  int           rdy_mode = 0;  // 0 always ready, 1 toggle, 2 random
  int           pulse_cnt = 0;
  logic [63:0]  cap_tts;
  logic [15:0]  cap_port, cap_len;
  logic [31:0]  cap_seq;
  logic [7:0]   hdr_b [58];

  typedef struct {
    string       name;
    logic [15:0] dport;
    logic [15:0] port;
    logic [15:0] len;
    logic [31:0] seq;
    int          n_pay;
    int          rdy_mode;
    int          exp_beats;
    logic        exp_err;
    logic        chk_pulse;
    logic        exp_pulse;
    int          ok, hdr, lenerr, gap;  // cumulative counter values after the frame
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  // Payload monitor: every accepted output beat is compared with the queue head.
  always @(negedge clk) begin
    if (m_if.valid && m_if.ready) begin
      n_tests++;
      act_b = {m_if.last, m_if.err, m_if.data};
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_beat: got {last,err,data}=%0h, required no beat", act_b);
      end else begin
        exp_b = exp_q.pop_front();
        if (act_b !== exp_b) begin
          n_fail++;
          $display("FAIL beat: got {last,err,data}=%0h, required %0h", act_b, exp_b);
        end
      end
    end
    if (hdr_valid) begin
      pulse_cnt++;
      cap_tts = hdr_tts; cap_port = hdr_port; cap_len = hdr_len; cap_seq = hdr_seq;
    end
  end

  // m_ready driver
  initial begin
    m_if.ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (rdy_mode == 1)      m_if.ready = ~m_if.ready;
      else if (rdy_mode == 2) m_if.ready = 1'($urandom_range(0, 1));
      else                    m_if.ready = 1'b1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] d, input logic l);
    int guard;
    guard = 0;
    s_if.valid = 1'b1; s_if.data = d; s_if.last = l;
    @(negedge clk);
    while (!s_if.ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!s_if.ready) begin
      n_tests++; n_fail++;
      $display("FAIL ready_timeout: got s_ready=0 for 200 cycles, required 1");
    end
    @(posedge clk); #1;
    s_if.valid = 1'b0;
  endtask

  task automatic fill_hdr(input logic [15:0] dport, input logic [15:0] port,
                          input logic [15:0] len, input logic [31:0] seq,
                          input logic [63:0] tts);
    for (int i = 0; i < 58; i++) hdr_b[i] = 8'(8'h80 + i);  // junk in ignored bytes
    hdr_b[0] = 8'h01; hdr_b[1] = 8'h00; hdr_b[2] = 8'h5e;
    hdr_b[3] = 8'h02; hdr_b[4] = 8'h03; hdr_b[5] = 8'h04;
    hdr_b[6] = 8'hf1; hdr_b[7] = 8'hf2; hdr_b[8] = 8'hf3;
    hdr_b[9] = 8'hf4; hdr_b[10] = 8'hf5; hdr_b[11] = 8'hf6;
    hdr_b[12] = 8'h08; hdr_b[13] = 8'h00; hdr_b[14] = 8'h45; hdr_b[23] = 8'h11;
    hdr_b[26] = 8'h07; hdr_b[27] = 8'h08; hdr_b[28] = 8'h09; hdr_b[29] = 8'h0a;
    hdr_b[30] = 8'h01; hdr_b[31] = 8'h02; hdr_b[32] = 8'h03; hdr_b[33] = 8'h04;
    hdr_b[34] = 8'h0b; hdr_b[35] = 8'h0c;
    hdr_b[36] = dport[15:8]; hdr_b[37] = dport[7:0];
    for (int i = 0; i < 8; i++) hdr_b[42+i] = tts[63-8*i -: 8];
    hdr_b[50] = port[15:8]; hdr_b[51] = port[7:0];
    hdr_b[52] = len[15:8];  hdr_b[53] = len[7:0];
    for (int i = 0; i < 4; i++) hdr_b[54+i] = seq[31-8*i -: 8];
  endtask

  task automatic run_vec(input vec_t v);
    int          p0;
    logic [63:0] tts;
    logic        lst;
    tts = {32'hc0ffee00, v.seq};
    fill_hdr(v.dport, v.port, v.len, v.seq, tts);
    p0 = pulse_cnt;
    for (int j = 0; j < v.exp_beats; j++) begin
      lst = (j == v.n_pay - 1);
      exp_q.push_back({lst, lst && v.exp_err, 8'(j)});
    end
    rdy_mode = v.rdy_mode;
    for (int i = 0; i < 58; i++) send_byte(hdr_b[i], (i == 57) && (v.n_pay == 0));
    for (int j = 0; j < v.n_pay; j++) send_byte(8'(j), j == v.n_pay - 1);
    repeat (4) @(posedge clk);
    #1;
    rdy_mode = 0;
    check({v.name, " beats_missing"}, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    check({v.name, " cnt_ok"},      64'(cnt_ok),  64'(v.ok));
    check({v.name, " cnt_hdr_err"}, 64'(cnt_hdr), 64'(v.hdr));
    check({v.name, " cnt_len_err"}, 64'(cnt_len), 64'(v.lenerr));
    check({v.name, " cnt_seq_gap"}, 64'(cnt_gap), 64'(v.gap));
    if (v.chk_pulse) begin
      check({v.name, " hdr_pulses"}, 64'(pulse_cnt - p0), 64'(v.exp_pulse));
      if (v.exp_pulse) begin
        check({v.name, " hdr_tts"},  cap_tts,         tts);
        check({v.name, " hdr_port"}, 64'(cap_port),   64'(v.port));
        check({v.name, " hdr_len"},  64'(cap_len),    64'(v.len));
        check({v.name, " hdr_seq"},  64'(cap_seq),    64'(v.seq));
      end
    end
  endtask

  // ---------------- test ----------------
  initial begin
    //              name           dport     port  len    seq    npay rdy beats err cp ep  ok hdr len gap
    vecs[0] = '{"good_p0",     16'h0506, 16'd0, 16'd64, 32'd5,  64, 0, 64, 1'b0, 1'b1, 1'b1, 1, 0, 0, 0};
    vecs[1] = '{"bad_dport",   16'h0507, 16'd0, 16'd64, 32'd6,  64, 0,  0, 1'b0, 1'b1, 1'b0, 1, 1, 0, 0};
    vecs[2] = '{"mrdy_toggle", 16'h0506, 16'd0, 16'd64, 32'd6,  64, 1, 64, 1'b0, 1'b1, 1'b1, 2, 1, 0, 0};
    vecs[3] = '{"short_pay",   16'h0506, 16'd0, 16'd64, 32'd7,  60, 0, 60, 1'b1, 1'b1, 1'b1, 2, 1, 1, 0};
    vecs[4] = '{"p1_seq7",     16'h0506, 16'd1, 16'd16, 32'd7,  16, 0, 16, 1'b0, 1'b1, 1'b1, 3, 1, 1, 0};
    vecs[5] = '{"p1_seq8",     16'h0506, 16'd1, 16'd16, 32'd8,  16, 0, 16, 1'b0, 1'b1, 1'b1, 4, 1, 1, 0};
    vecs[6] = '{"p1_seq10",    16'h0506, 16'd1, 16'd16, 32'd10, 16, 0, 16, 1'b0, 1'b1, 1'b1, 5, 1, 1, 1};
    vecs[7] = '{"bad_port",    16'h0506, 16'd2, 16'd16, 32'd0,  16, 0,  0, 1'b0, 1'b1, 1'b0, 5, 2, 1, 1};
    vecs[8] = '{"long_pay",    16'h0506, 16'd0, 16'd32, 32'd8,  40, 2, 40, 1'b1, 1'b1, 1'b1, 5, 2, 2, 1};
    vecs[9] = '{"zero_pay",    16'h0506, 16'd1, 16'd16, 32'd11,  0, 0,  0, 1'b0, 1'b0, 1'b0, 5, 2, 3, 1};

    s_if.valid = 1'b0; s_if.data = 8'h00; s_if.last = 1'b0; s_if.err = 1'b0;

    // reset state
    #12;
    check("rst s_ready",   64'(s_if.ready),  64'd0);
    check("rst m_valid",   64'(m_if.valid),  64'd0);
    check("rst hdr_valid", 64'(hdr_valid),   64'd0);
    check("rst cnt_ok",    64'(cnt_ok),      64'd0);
    check("rst state",     64'(dbg_state),   64'(ST_HDR));
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst s_ready", 64'(s_if.ready), 64'd1);

    for (int k = 0; k < 10; k++) run_vec(vecs[k]);

    // runt frame (30 bytes) then a valid frame forwarded intact
    fill_hdr(16'h0506, 16'd0, 16'd8, 32'd9, 64'h0);
    for (int i = 0; i < 30; i++) send_byte(hdr_b[i], i == 29);
    repeat (3) @(posedge clk); #1;
    check("runt cnt_hdr_err", 64'(cnt_hdr), 64'd3);
    check("runt state",       64'(dbg_state), 64'(ST_HDR));
    run_vec('{"after_runt", 16'h0506, 16'd0, 16'd8, 32'd9, 8, 0, 8, 1'b0, 1'b1, 1'b1, 6, 3, 3, 1});

    // reset pulse in the middle of a payload
    fill_hdr(16'h0506, 16'd1, 16'd32, 32'd20, 64'h0);
    for (int j = 0; j < 10; j++) exp_q.push_back({1'b0, 1'b0, 8'(j)});
    for (int i = 0; i < 58; i++) send_byte(hdr_b[i], 1'b0);
    for (int j = 0; j < 10; j++) send_byte(8'(j), 1'b0);
    check("midrst state_before", 64'(dbg_state), 64'(ST_PAY));
    s_if.valid = 1'b1; s_if.data = 8'h55; s_if.last = 1'b1;
    rst_n = 1'b0;
    #1;
    check("midrst m_valid",   64'(m_if.valid), 64'd0);
    check("midrst m_data",    64'(m_if.data),  64'd0);
    check("midrst m_last",    64'(m_if.last),  64'd0);
    check("midrst m_err",     64'(m_if.err),   64'd0);
    check("midrst s_ready",   64'(s_if.ready), 64'd0);
    check("midrst hdr_tts",   hdr_tts,         64'd0);
    check("midrst hdr_seq",   64'(hdr_seq),    64'd0);
    check("midrst cnt_ok",    64'(cnt_ok),     64'd0);
    check("midrst cnt_hdr",   64'(cnt_hdr),    64'd0);
    check("midrst cnt_len",   64'(cnt_len),    64'd0);
    check("midrst cnt_gap",   64'(cnt_gap),    64'd0);
    check("midrst state",     64'(dbg_state),  64'(ST_HDR));
    check("midrst beats_missing", 64'(exp_q.size()), 64'd0);
    s_if.valid = 1'b0; s_if.last = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    // port 1 was seen before reset; a clean seen table means no gap here
    run_vec('{"after_rst", 16'h0506, 16'd1, 16'd4, 32'd100, 4, 0, 4, 1'b0, 1'b1, 1'b1, 1, 0, 0, 0});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at 2ms, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
